// File: rtl/key_irq_pkg.sv
// Shared types and defaults for the keyboard interrupt queue.
package key_irq_pkg;

    localparam int DEPTH_DEFAULT  = 8;
    localparam int CODE_W_DEFAULT = 9;
    localparam int INTDATA_W      = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_REL = 2'd2
    } irqState_t;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous scan-code FIFO with same-cycle push and pop support.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module key_fifo import key_irq_pkg::*; #(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int CODE_W = CODE_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [CODE_W-1:0]          wrData,
    output logic [CODE_W-1:0]          rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic              doWrite;
    logic              doRead;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign doRead  = pop & ~empty;
    assign doWrite = push & (~full | doRead);
    assign rdData  = mem[rdPtr];

    // Storage array; written only when a push is accepted, never reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doRead) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({doWrite, doRead})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_irq_queue.sv
// Buffers key presses and hands them to the CPU one interrupt per code.
// A long acknowledge level only consumes one entry thanks to the WAIT_REL state.
module key_irq_queue import key_irq_pkg::*; #(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int CODE_W = CODE_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pressed,
    input  logic [CODE_W-1:0]          pressedKey,
    input  logic                       enable,
    input  logic                       ack,
    input  logic                       clearOvf,
    output logic                       irq,
    output logic [INTDATA_W-1:0]       intData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    irqState_t         state;
    irqState_t         stateNext;
    logic              pressedPrev;
    logic              ackPrev;
    logic              pushReq;
    logic              ackRise;
    logic              popReq;
    logic              loadData;
    logic              irqNext;
    logic              dropCode;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CODE_W-1:0] fifoHead;

    assign pushReq  = pressed & ~pressedPrev & enable;
    assign ackRise  = ack & ~ackPrev;
    assign dropCode = pushReq & fifoFull & ~popReq;

    key_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pushReq),
        .pop    (popReq),
        .wrData (pressedKey),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    // Edge detectors track their inputs even in reset so held levels never look like edges.
    always_ff @(posedge clk) begin
        pressedPrev <= pressed;
        ackPrev     <= ack;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic for the interrupt handshake.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (!fifoEmpty) stateNext = PRESENT;
            PRESENT:  if (ackRise)    stateNext = WAIT_REL;
            WAIT_REL: if (!ack)       stateNext = IDLE;
            default:                  stateNext = IDLE;
        endcase
    end

    // Output decode: when to load the head, pop it, and what irq should become.
    always_comb begin
        loadData = 1'b0;
        popReq   = 1'b0;
        irqNext  = 1'b0;
        case (state)
            IDLE: begin
                loadData = ~fifoEmpty;
                irqNext  = ~fifoEmpty;
            end
            PRESENT: begin
                popReq  = ackRise;
                irqNext = ~ackRise;
            end
            default: begin
                irqNext = 1'b0;
            end
        endcase
    end

    // Registered interrupt outputs; intData keeps its last value after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq     <= 1'b0;
            intData <= '0;
        end else begin
            irq <= irqNext;
            if (loadData) begin
                intData <= {{(INTDATA_W-CODE_W){1'b0}}, fifoHead};
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (dropCode) begin
            overflow <= 1'b1;
        end else if (clearOvf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_irq_queue.sv
// Directed testbench for key_irq_queue with hand-computed expectations.
module tb_key_irq_queue;

    logic        clk;
    logic        rst;
    logic        pressed;
    logic [8:0]  pressedKey;
    logic        enable;
    logic        ack;
    logic        clearOvf;
    logic        irq;
    logic [15:0] intData;
    logic [3:0]  count;
    logic        overflow;

    int testsRun;
    int failCount;

    key_irq_queue #(
        .DEPTH  (8),
        .CODE_W (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pressed    (pressed),
        .pressedKey (pressedKey),
        .enable     (enable),
        .ack        (ack),
        .clearOvf   (clearOvf),
        .irq        (irq),
        .intData    (intData),
        .count      (count),
        .overflow   (overflow)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One press edge of a code followed by a release cycle.
    task automatic applyStimulus(input logic [8:0] code);
        pressed    = 1'b1;
        pressedKey = code;
        tick(1);
        pressed    = 1'b0;
        tick(1);
    endtask

    // Pop the presented code with a 1-cycle ack and wait for the next presentation.
    task automatic drainOne(input string tag, input logic [15:0] expData);
        checkOutput({tag, "_irq"}, {31'd0, irq}, 32'd1);
        checkOutput({tag, "_data"}, {16'd0, intData}, {16'd0, expData});
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
    endtask

    logic [15:0] burstExp [3];
    logic [15:0] ovfExp [8];

    // Linear directed test sequence.
    initial begin
        testsRun   = 0;
        failCount  = 0;
        rst        = 1'b1;
        pressed    = 1'b0;
        pressedKey = '0;
        enable     = 1'b0;
        ack        = 1'b0;
        clearOvf   = 1'b0;
        tick(2);

        // Reset values
        checkOutput("rst_irq",  {31'd0, irq},      32'd0);
        checkOutput("rst_data", {16'd0, intData},  32'd0);
        checkOutput("rst_cnt",  {28'd0, count},    32'd0);
        checkOutput("rst_ovf",  {31'd0, overflow}, 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        tick(1);

        // Single key, press held 3 cycles
        pressed    = 1'b1;
        pressedKey = 9'h01C;
        tick(1);
        checkOutput("single_cnt", {28'd0, count}, 32'd1);
        checkOutput("single_irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        checkOutput("single_irq", {31'd0, irq}, 32'd1);
        checkOutput("single_data", {16'd0, intData}, 32'h001C);
        tick(1);
        pressed = 1'b0;
        checkOutput("single_hold_cnt", {28'd0, count}, 32'd1);
        ack = 1'b1;
        tick(1);
        checkOutput("single_ack_irq", {31'd0, irq}, 32'd0);
        checkOutput("single_ack_cnt", {28'd0, count}, 32'd0);
        tick(4);
        checkOutput("single_longack_cnt", {28'd0, count}, 32'd0);
        checkOutput("single_longack_irq", {31'd0, irq}, 32'd0);
        ack = 1'b0;
        tick(2);
        checkOutput("single_idle_irq", {31'd0, irq}, 32'd0);
        checkOutput("single_keep_data", {16'd0, intData}, 32'h001C);

        // Burst of three codes with 2-cycle acks
        burstExp[0] = 16'h004D;
        burstExp[1] = 16'h0032;
        burstExp[2] = 16'h0021;
        applyStimulus(9'h04D);
        applyStimulus(9'h032);
        applyStimulus(9'h021);
        checkOutput("burst_cnt", {28'd0, count}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("burst%0d_irq", i), {31'd0, irq}, 32'd1);
            checkOutput($sformatf("burst%0d_data", i), {16'd0, intData}, {16'd0, burstExp[i]});
            ack = 1'b1;
            tick(1);
            checkOutput($sformatf("burst%0d_ack_irq", i), {31'd0, irq}, 32'd0);
            checkOutput($sformatf("burst%0d_cnt", i), {28'd0, count}, 32'(2 - i));
            tick(1);
            ack = 1'b0;
            tick(1);
            checkOutput($sformatf("burst%0d_gap_irq", i), {31'd0, irq}, 32'd0);
            tick(1);
        end
        checkOutput("burst_end_irq", {31'd0, irq}, 32'd0);
        checkOutput("burst_end_cnt", {28'd0, count}, 32'd0);

        // Overflow: nine codes, no ack
        for (int i = 0; i < 8; i++) begin
            applyStimulus(9'(9'h101 + i));
        end
        checkOutput("ovf_full_cnt", {28'd0, count}, 32'd8);
        checkOutput("ovf_before", {31'd0, overflow}, 32'd0);
        applyStimulus(9'h109);
        checkOutput("ovf_cnt", {28'd0, count}, 32'd8);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        clearOvf = 1'b1;
        tick(1);
        clearOvf = 1'b0;
        checkOutput("ovf_clear", {31'd0, overflow}, 32'd0);
        // Clear and drop in the same cycle: set wins
        pressed    = 1'b1;
        pressedKey = 9'h10A;
        clearOvf   = 1'b1;
        tick(1);
        pressed  = 1'b0;
        clearOvf = 1'b0;
        checkOutput("ovf_setwins", {31'd0, overflow}, 32'd1);
        clearOvf = 1'b1;
        tick(1);
        clearOvf = 1'b0;
        checkOutput("ovf_clear2", {31'd0, overflow}, 32'd0);

        // Full FIFO: press edge together with ack rise in PRESENT
        checkOutput("fullpop_data0", {16'd0, intData}, 32'h0101);
        pressed    = 1'b1;
        pressedKey = 9'h02B;
        ack        = 1'b1;
        tick(1);
        checkOutput("fullpop_cnt", {28'd0, count}, 32'd8);
        checkOutput("fullpop_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("fullpop_irq", {31'd0, irq}, 32'd0);
        pressed = 1'b0;
        ack     = 1'b0;
        tick(2);
        for (int i = 0; i < 7; i++) begin
            ovfExp[i] = 16'(16'h0102 + i);
        end
        ovfExp[7] = 16'h002B;
        for (int i = 0; i < 8; i++) begin
            drainOne($sformatf("drain%0d", i), ovfExp[i]);
        end
        checkOutput("drain_end_cnt", {28'd0, count}, 32'd0);
        checkOutput("drain_end_irq", {31'd0, irq}, 32'd0);

        // Gating: enable low blocks pushes
        enable = 1'b0;
        applyStimulus(9'h043);
        tick(1);
        checkOutput("gate_cnt", {28'd0, count}, 32'd0);
        checkOutput("gate_irq", {31'd0, irq}, 32'd0);
        enable = 1'b1;

        // Ack rise in IDLE is ignored; held ack must not block the next code
        ack = 1'b1;
        tick(1);
        applyStimulus(9'h05A);
        checkOutput("idleack_irq", {31'd0, irq}, 32'd1);
        checkOutput("idleack_data", {16'd0, intData}, 32'h005A);
        checkOutput("idleack_cnt", {28'd0, count}, 32'd1);
        ack = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        checkOutput("idleack_pop_cnt", {28'd0, count}, 32'd0);
        ack = 1'b0;
        tick(2);

        // Pressed held high across reset release: no push
        rst        = 1'b1;
        pressed    = 1'b1;
        pressedKey = 9'h077;
        tick(2);
        rst = 1'b0;
        tick(2);
        checkOutput("rstheld_cnt", {28'd0, count}, 32'd0);
        checkOutput("rstheld_irq", {31'd0, irq}, 32'd0);
        pressed = 1'b0;
        tick(1);

        // Reset mid-operation in PRESENT with three entries
        applyStimulus(9'h011);
        applyStimulus(9'h022);
        applyStimulus(9'h033);
        checkOutput("midrst_pre_cnt", {28'd0, count}, 32'd3);
        checkOutput("midrst_pre_irq", {31'd0, irq}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("midrst_irq",  {31'd0, irq},      32'd0);
        checkOutput("midrst_data", {16'd0, intData},  32'd0);
        checkOutput("midrst_cnt",  {28'd0, count},    32'd0);
        checkOutput("midrst_ovf",  {31'd0, overflow}, 32'd0);
        tick(2);
        checkOutput("midrst_after_irq", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
